// File: rtl/axi_lite_cfg_master_if.sv
// Command port plus the five AXI4-Lite channels of the configuration master.
// The master modport is the DUT side; the slave modport is the command source / AXI slave side.
interface axi_lite_cfg_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      i_cmd_valid;
   logic                      o_cmd_ready;
   logic                      i_cmd_write;
   logic [ADDR_WIDTH-1:0]     i_cmd_addr;
   logic [DATA_WIDTH-1:0]     i_cmd_wdata;
   logic [DATA_WIDTH/8-1:0]   i_cmd_wstrb;
   logic                      o_rsp_valid;
   logic [DATA_WIDTH-1:0]     o_rsp_rdata;
   logic [1:0]                o_rsp_resp;
   logic [ADDR_WIDTH-1:0]     o_awaddr;
   logic                      o_awvalid;
   logic                      i_awready;
   logic [DATA_WIDTH-1:0]     o_wdata;
   logic [DATA_WIDTH/8-1:0]   o_wstrb;
   logic                      o_wvalid;
   logic                      i_wready;
   logic                      i_bvalid;
   logic [1:0]                i_bresp;
   logic                      o_bready;
   logic [ADDR_WIDTH-1:0]     o_araddr;
   logic                      o_arvalid;
   logic                      i_arready;
   logic                      i_rvalid;
   logic [DATA_WIDTH-1:0]     i_rdata;
   logic [1:0]                i_rresp;
   logic                      o_rready;

   modport master (
      input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb,
      output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp,
      output o_awaddr, o_awvalid, input i_awready,
      output o_wdata, o_wstrb, o_wvalid, input i_wready,
      input  i_bvalid, i_bresp, output o_bready,
      output o_araddr, o_arvalid, input i_arready,
      input  i_rvalid, i_rdata, i_rresp, output o_rready
   );

   modport slave (
      output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb,
      input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp,
      input  o_awaddr, o_awvalid, output i_awready,
      input  o_wdata, o_wstrb, o_wvalid, output i_wready,
      output i_bvalid, i_bresp, input o_bready,
      input  o_araddr, o_arvalid, output i_arready,
      output i_rvalid, i_rdata, i_rresp, input o_rready
   );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction out,
// one-cycle response pulse back. A watchdog aborts transactions the slave never finishes.
module axi_lite_cfg_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  i_aclk,
   input  logic                  i_areset,
   axi_lite_cfg_master_if.master bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
   // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1, so the
   // response pulse lands exactly TIMEOUT_CYCLES cycles after accept.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    active;
   logic                    timeout;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      active  = (state_q != IDLE) && (state_q != DONE);
      timeout = active && (cnt_q == CNT_LAST);
      if (active) cnt_d = cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (bus.i_cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               cnt_d       = '0;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               addr_d      = bus.i_cmd_addr;
               if (bus.i_cmd_write) begin
                  wdata_d   = bus.i_cmd_wdata;
                  wstrb_d   = bus.i_cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            aw_done_d = aw_done_q | (awvalid_q & bus.i_awready);
            w_done_d  = w_done_q  | (wvalid_q  & bus.i_wready);
            awvalid_d = awvalid_q & ~bus.i_awready;
            wvalid_d  = wvalid_q  & ~bus.i_wready;
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bus.i_bvalid) begin
               bready_d    = 1'b0;
               rsp_resp_d  = bus.i_bresp;
               rsp_rdata_d = '0;
               rsp_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         RD_REQ: begin
            if (bus.i_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.i_rvalid) begin
               rready_d    = 1'b0;
               rsp_resp_d  = bus.i_rresp;
               rsp_rdata_d = bus.i_rdata;
               rsp_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase

      // A genuine completion on the timeout edge wins; otherwise the watchdog aborts.
      if (timeout && (state_d != DONE)) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rsp_resp_d  = 2'b11;
         rsp_rdata_d = '0;
         rsp_valid_d = 1'b1;
         state_d     = DONE;
      end
   end

   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign bus.o_cmd_ready = cmd_ready_q;
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_rsp_rdata = rsp_rdata_q;
   assign bus.o_rsp_resp  = rsp_resp_q;
   assign bus.o_awaddr    = addr_q;
   assign bus.o_awvalid   = awvalid_q;
   assign bus.o_wdata     = wdata_q;
   assign bus.o_wstrb     = wstrb_q;
   assign bus.o_wvalid    = wvalid_q;
   assign bus.o_bready    = bready_q;
   assign bus.o_araddr    = addr_q;
   assign bus.o_arvalid   = arvalid_q;
   assign bus.o_rready    = rready_q;
endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Directed self-checking bench for axi_lite_cfg_master; inputs are driven and
// outputs sampled on the falling clock edge, cycle k = k-th falling edge after accept.
module tb_axi_lite_cfg_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic i_aclk = 1'b0;
   logic i_areset;
   int   checks = 0;
   int   errors = 0;
   logic [DW-1:0] mem_word;

   axi_lite_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_lite_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_aclk   (i_aclk),
      .i_areset (i_areset),
      .bus      (bus)
   );

   always #5 i_aclk = ~i_aclk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic step();
      @(negedge i_aclk);
   endtask

   task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_write = wr;
      bus.i_cmd_addr  = a;
      bus.i_cmd_wdata = d;
      bus.i_cmd_wstrb = 4'hF;
   endtask

   task automatic test_reset();
      i_areset = 1'b1;
      bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = '0;
      bus.i_cmd_wdata = '0;   bus.i_cmd_wstrb = '0;
      bus.i_awready = 1'b0; bus.i_wready = 1'b0; bus.i_bvalid = 1'b0; bus.i_bresp = 2'b00;
      bus.i_arready = 1'b0; bus.i_rvalid = 1'b0; bus.i_rdata = '0;    bus.i_rresp = 2'b00;
      step(); step();
      i_areset = 1'b0;
      step();
      checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.o_cmd_ready); end
      checks++; if ({bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready} !== 5'b0) begin
         errors++; $display("FAIL reset_valids: got %b expected 00000",
            {bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready}); end
      checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.o_rsp_valid); end
      checks++; if (bus.o_rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", bus.o_rsp_rdata); end
      checks++; if (bus.o_rsp_resp !== 2'b00) begin errors++; $display("FAIL reset_rsp_resp: got %b expected 00", bus.o_rsp_resp); end
      checks++; if ({bus.o_awaddr, bus.o_wdata, bus.o_wstrb, bus.o_araddr} !== '0) begin
         errors++; $display("FAIL reset_addr_data: got %h/%h/%h/%h expected 0", bus.o_awaddr, bus.o_wdata, bus.o_wstrb, bus.o_araddr); end
   endtask

   task automatic test_write_zero_wait();
      bus.i_awready = 1'b1; bus.i_wready = 1'b1;
      checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr0_ready_before: got %b expected 1", bus.o_cmd_ready); end
      drive_cmd(1'b1, 32'h0, 32'hDEADBEEF);
      step(); // k=1
      bus.i_cmd_valid = 1'b0;
      checks++; if ({bus.o_awvalid, bus.o_wvalid} !== 2'b11) begin errors++; $display("FAIL wr0_aw_w_same_cycle: got %b expected 11", {bus.o_awvalid, bus.o_wvalid}); end
      checks++; if (bus.o_cmd_ready !== 1'b0) begin errors++; $display("FAIL wr0_ready_busy: got %b expected 0", bus.o_cmd_ready); end
      checks++; if ({bus.o_awaddr, bus.o_wdata, bus.o_wstrb} !== {32'h0, 32'hDEADBEEF, 4'hF}) begin
         errors++; $display("FAIL wr0_fields: got %h %h %h expected 0 deadbeef f", bus.o_awaddr, bus.o_wdata, bus.o_wstrb); end
      mem_word = bus.o_wdata;
      step(); // k=2
      checks++; if ({bus.o_awvalid, bus.o_wvalid, bus.o_bready} !== 3'b001) begin
         errors++; $display("FAIL wr0_wresp_state: got %b expected 001", {bus.o_awvalid, bus.o_wvalid, bus.o_bready}); end
      bus.i_bvalid = 1'b1; bus.i_bresp = 2'b00;
      step(); // k=3
      bus.i_bvalid = 1'b0;
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_resp} !== 3'b100) begin
         errors++; $display("FAIL wr0_rsp: got valid=%b resp=%b expected 1/00", bus.o_rsp_valid, bus.o_rsp_resp); end
      checks++; if (bus.o_rsp_rdata !== '0) begin errors++; $display("FAIL wr0_rsp_rdata: got %h expected 0", bus.o_rsp_rdata); end
      step(); // k=4
      checks++; if ({bus.o_rsp_valid, bus.o_cmd_ready, bus.o_bready} !== 3'b010) begin
         errors++; $display("FAIL wr0_after: got rsp=%b ready=%b bready=%b expected 0/1/0", bus.o_rsp_valid, bus.o_cmd_ready, bus.o_bready); end
   endtask

   task automatic test_read_zero_wait();
      bus.i_arready = 1'b1;
      drive_cmd(1'b0, 32'h0, 32'h0);
      step(); // k=1
      bus.i_cmd_valid = 1'b0;
      checks++; if ({bus.o_arvalid, bus.o_rready, bus.o_araddr} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL rd0_ar: got arvalid=%b rready=%b araddr=%h expected 1/0/0", bus.o_arvalid, bus.o_rready, bus.o_araddr); end
      step(); // k=2
      checks++; if ({bus.o_arvalid, bus.o_rready} !== 2'b01) begin
         errors++; $display("FAIL rd0_rdata_state: got %b expected 01", {bus.o_arvalid, bus.o_rready}); end
      bus.i_rvalid = 1'b1; bus.i_rdata = mem_word; bus.i_rresp = 2'b00;
      step(); // k=3
      bus.i_rvalid = 1'b0; bus.i_rdata = '0;
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
         errors++; $display("FAIL rd0_rsp: got valid=%b resp=%b rdata=%h expected 1/00/deadbeef", bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata); end
      step(); // k=4
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL rd0_rsp_hold: got valid=%b rdata=%h expected 0/deadbeef", bus.o_rsp_valid, bus.o_rsp_rdata); end
   endtask

   task automatic test_write_wready_delay();
      int bad;
      bus.i_awready = 1'b1; bus.i_wready = 1'b0;
      drive_cmd(1'b1, 32'h4, 32'hCAFEBABE);
      step(); // k=1: AW handshake at the next edge
      bus.i_cmd_valid = 1'b0;
      checks++; if ({bus.o_awvalid, bus.o_wvalid, bus.o_awaddr} !== {2'b11, 32'h4}) begin
         errors++; $display("FAIL wrd_start: got aw=%b w=%b addr=%h expected 1/1/4", bus.o_awvalid, bus.o_wvalid, bus.o_awaddr); end
      step(); // k=2
      bus.i_awready = 1'b0;
      checks++; if ({bus.o_awvalid, bus.o_wvalid, bus.o_bready} !== 3'b010) begin
         errors++; $display("FAIL wrd_aw_first: got %b expected 010", {bus.o_awvalid, bus.o_wvalid, bus.o_bready}); end
      bad = 0;
      for (int k = 3; k <= 5; k++) begin
         // early B with an error code must be ignored outside WR_RESP
         bus.i_bvalid = 1'b1; bus.i_bresp = 2'b10;
         step();
         if ({bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_rsp_valid} !== 4'b0100 || bus.o_wdata !== 32'hCAFEBABE) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL wrd_w_hold: got %0d bad cycles expected 0", bad); end
      bus.i_bvalid = 1'b0; bus.i_bresp = 2'b00;
      step(); // k=6: W handshake at the next edge
      bus.i_wready = 1'b1;
      checks++; if ({bus.o_wvalid, bus.o_wdata} !== {1'b1, 32'hCAFEBABE}) begin
         errors++; $display("FAIL wrd_w_k6: got w=%b data=%h expected 1/cafebabe", bus.o_wvalid, bus.o_wdata); end
      step(); // k=7
      bus.i_wready = 1'b0;
      checks++; if ({bus.o_wvalid, bus.o_bready} !== 2'b01) begin
         errors++; $display("FAIL wrd_wresp: got %b expected 01", {bus.o_wvalid, bus.o_bready}); end
      bus.i_bvalid = 1'b1; bus.i_bresp = 2'b00;
      step(); // k=8
      bus.i_bvalid = 1'b0;
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata} !== {1'b1, 2'b00, 32'h0}) begin
         errors++; $display("FAIL wrd_rsp: got valid=%b resp=%b rdata=%h expected 1/00/0", bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata); end
      step(); // k=9
      checks++; if ({bus.o_rsp_valid, bus.o_bready, bus.o_cmd_ready} !== 3'b001) begin
         errors++; $display("FAIL wrd_single_b: got %b expected 001", {bus.o_rsp_valid, bus.o_bready, bus.o_cmd_ready}); end
   endtask

   task automatic test_read_timeout();
      int bad;
      bus.i_arready = 1'b1; bus.i_rvalid = 1'b0;
      drive_cmd(1'b0, 32'h8, 32'h0);
      step(); // k=1
      bus.i_cmd_valid = 1'b0;
      checks++; if ({bus.o_arvalid, bus.o_araddr} !== {1'b1, 32'h8}) begin
         errors++; $display("FAIL to_ar: got arvalid=%b araddr=%h expected 1/8", bus.o_arvalid, bus.o_araddr); end
      bad = 0;
      for (int k = 2; k <= TO - 1; k++) begin
         step();
         if ({bus.o_rready, bus.o_rsp_valid} !== 2'b10) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL to_wait: got %0d bad cycles expected 0", bad); end
      step(); // k=16
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata, bus.o_rready} !== {1'b1, 2'b11, 32'h0, 1'b0}) begin
         errors++; $display("FAIL to_rsp: got valid=%b resp=%b rdata=%h rready=%b expected 1/11/0/0",
            bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata, bus.o_rready); end
      step(); // k=17
      checks++; if ({bus.o_rsp_valid, bus.o_cmd_ready} !== 2'b01) begin
         errors++; $display("FAIL to_recover: got rsp=%b ready=%b expected 0/1", bus.o_rsp_valid, bus.o_cmd_ready); end
      drive_cmd(1'b0, 32'h0, 32'h0);
      step(); // k=1 of follow-up read
      bus.i_cmd_valid = 1'b0;
      step(); // k=2
      bus.i_rvalid = 1'b1; bus.i_rdata = mem_word; bus.i_rresp = 2'b00;
      step(); // k=3
      bus.i_rvalid = 1'b0; bus.i_rdata = '0;
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
         errors++; $display("FAIL to_next_cmd: got valid=%b resp=%b rdata=%h expected 1/00/deadbeef", bus.o_rsp_valid, bus.o_rsp_resp, bus.o_rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      int bad;
      bus.i_awready = 1'b1; bus.i_wready = 1'b1; bus.i_arready = 1'b1;
      step();
      drive_cmd(1'b1, 32'h10, 32'h1);
      step(); // k=1: second command presented while busy
      drive_cmd(1'b0, 32'h10, 32'h0);
      checks++; if ({bus.o_awvalid, bus.o_awaddr, bus.o_wdata} !== {1'b1, 32'h10, 32'h1}) begin
         errors++; $display("FAIL b2b_first_fields: got aw=%b addr=%h data=%h expected 1/10/1", bus.o_awvalid, bus.o_awaddr, bus.o_wdata); end
      bad = 0;
      if (bus.o_cmd_ready !== 1'b0) bad++;
      step(); // k=2
      if (bus.o_cmd_ready !== 1'b0 || bus.o_arvalid !== 1'b0) bad++;
      bus.i_bvalid = 1'b1; bus.i_bresp = 2'b00;
      step(); // k=3
      bus.i_bvalid = 1'b0;
      if (bus.o_cmd_ready !== 1'b0 || bus.o_arvalid !== 1'b0) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_not_queued: got %0d bad cycles expected 0", bad); end
      checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_rsp: got %b expected 1", bus.o_rsp_valid); end
      step(); // k=4: second command accepted at the next edge
      checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_k4: got %b expected 1", bus.o_cmd_ready); end
      step(); // k=5
      bus.i_cmd_valid = 1'b0;
      checks++; if ({bus.o_arvalid, bus.o_araddr} !== {1'b1, 32'h10}) begin
         errors++; $display("FAIL b2b_second_ar: got arvalid=%b araddr=%h expected 1/10", bus.o_arvalid, bus.o_araddr); end
      step(); // k=6
      bus.i_rvalid = 1'b1; bus.i_rdata = 32'h1; bus.i_rresp = 2'b00;
      step(); // k=7
      bus.i_rvalid = 1'b0; bus.i_rdata = '0;
      checks++; if ({bus.o_rsp_valid, bus.o_rsp_rdata} !== {1'b1, 32'h1}) begin
         errors++; $display("FAIL b2b_second_rsp: got valid=%b rdata=%h expected 1/1", bus.o_rsp_valid, bus.o_rsp_rdata); end
   endtask

   task automatic test_reset_mid();
      bus.i_awready = 1'b1; bus.i_wready = 1'b1;
      step();
      drive_cmd(1'b1, 32'h20, 32'h5);
      step(); // k=1
      bus.i_cmd_valid = 1'b0;
      step(); // k=2
      checks++; if (bus.o_bready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_wresp: got bready=%b expected 1", bus.o_bready); end
      i_areset = 1'b1;
      bus.i_bvalid = 1'b1; bus.i_bresp = 2'b01;
      step(); // k=3
      i_areset = 1'b0;
      bus.i_bvalid = 1'b0;
      checks++; if ({bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready, bus.o_rsp_valid, bus.o_cmd_ready} !== 7'b0000001) begin
         errors++; $display("FAIL rst_mid_outputs: got %b expected 0000001",
            {bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready, bus.o_rsp_valid, bus.o_cmd_ready}); end
      checks++; if ({bus.o_rsp_resp, bus.o_rsp_rdata, bus.o_awaddr} !== '0) begin
         errors++; $display("FAIL rst_mid_data: got resp=%b rdata=%h addr=%h expected 0", bus.o_rsp_resp, bus.o_rsp_rdata, bus.o_awaddr); end
      step(); // k=4
      checks++; if ({bus.o_rsp_valid, bus.o_cmd_ready} !== 2'b01) begin
         errors++; $display("FAIL rst_mid_no_rsp: got rsp=%b ready=%b expected 0/1", bus.o_rsp_valid, bus.o_cmd_ready); end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_zero_wait();
      test_write_wready_delay();
      test_read_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_lite_cfg_master.md
# axi_lite_cfg_master

Single-outstanding AXI4-Lite master that sequences register-bank accesses on behalf of the accelerator control logic. It accepts one simple command (write or read) on a valid/ready port and runs the full AXI-Lite handshake against a slave such as the accelerator configuration memory. It returns a one-cycle response pulse, and a watchdog aborts transactions the slave never completes.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 or 64)
- TIMEOUT_CYCLES, 256, watchdog limit per transaction (>=4)
- i_aclk  in  1  clock
- i_areset  in  1  synchronous, active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_WIDTH  byte address
- i_cmd_wdata  in  DATA_WIDTH  write data
- i_cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- o_rsp_resp  out  2  AXI resp; 2'b11 on timeout
- o_awaddr, o_awvalid / i_awready  out/out/in  ADDR_WIDTH,1,1  write address channel
- o_wdata, o_wstrb, o_wvalid / i_wready  out/out/out/in  DATA_WIDTH,DATA_WIDTH/8,1,1  write data channel
- i_bvalid, i_bresp / o_bready  in/in/out  1,2,1  write response channel
- o_araddr, o_arvalid / i_arready  out/out/in  ADDR_WIDTH,1,1  read address channel
- i_rvalid, i_rdata, i_rresp / o_rready  in/in/in/out  1,DATA_WIDTH,2,1  read data channel

## Operation
- FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: o_cmd_ready=1. On i_cmd_valid, command fields are registered; go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: o_awvalid and o_wvalid are both asserted. Each drops independently in the cycle after its own ready is sampled high (aw_done / w_done flags). Once both are done, go to WR_RESP.
- WR_RESP: o_bready=1. When i_bvalid is high, capture i_bresp and go to DONE.
- RD_REQ: o_arvalid=1 until i_arready, then RD_DATA.
- RD_DATA: o_rready=1. When i_rvalid is high, capture i_rdata/i_rresp and go to DONE.
- DONE: o_rsp_valid=1 for exactly one cycle, then IDLE.
- Watchdog: the counter clears on command accept and increments each cycle outside IDLE/DONE. When it reaches TIMEOUT_CYCLES-1:
  - all AXI valid/ready outputs drop the next cycle;
  - go to DONE with o_rsp_resp=2'b11 and rdata=0.
- Address, data and strobe outputs stay stable while their valid is high.
- Commands presented while o_cmd_ready=0 are ignored; they are not queued.

## Timing
- Reset: FSM=IDLE. All outputs are 0 except o_cmd_ready=1. Counter and flags clear.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command accepted at edge N. Valids are high from N+1.
- Zero-wait slave (all readies high, response the cycle after):
  - Write: AW/W handshake at N+1, B at N+2, o_rsp_valid at N+3.
  - Read: AR at N+1, R at N+2, o_rsp_valid at N+3.
- Minimum command-to-command spacing is 4 cycles; o_cmd_ready returns high in the cycle after DONE.
- i_bvalid or i_rvalid arriving before its request handshake completes is ignored until the FSM reaches WR_RESP/RD_DATA.
- o_rsp_rdata/o_rsp_resp hold their value until the next DONE.
- Reset asserted mid-transaction: all valid/ready outputs drop the next cycle and any in-flight response is discarded.

## Test plan
- Write 0xDEADBEEF to 0x0, zero-wait slave -> AW and W in the same cycle; o_rsp_valid 3 cycles after accept, resp 2'b00.
- Read 0x0 after the write -> o_rsp_rdata=0xDEADBEEF, resp 2'b00, latency 3.
- Write 0xCAFEBABE to 0x4, i_wready delayed 5 cycles after i_awready -> o_awvalid drops first, o_wvalid stays high until the W handshake; single B accepted; rsp resp 2'b00.
- Read with i_rvalid stalled and TIMEOUT_CYCLES=16 -> o_rready drops, rsp resp 2'b11 and rdata 0 exactly 16 cycles after accept; next command accepted normally.
- Back-to-back: i_cmd_valid held with a second command -> second accepted only after o_rsp_valid, spacing 4 cycles.
- Reset pulse during WR_RESP -> all outputs return to reset values, no o_rsp_valid, o_cmd_ready=1.
